// File: rtl/bias_sequencer_fire5_squeeze_pkg.sv
// ----------------------------------------------------------------------------
// fire5_squeeze_pkg: shared constants and FSM encoding for the fire5 squeeze
// bias sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fire5_squeeze_pkg;
  localparam int NUM_CH = 32;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;
  localparam int PIX_W  = 10;

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/bias_sequencer_fire5_squeeze_if.sv
// ----------------------------------------------------------------------------
// bias_sequencer_fire5_squeeze_if: accumulator input and activation output
// streams.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bias_sequencer_fire5_squeeze_if;
  import fire5_squeeze_pkg::*;

  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;

  // master: MAC array / expand buffer side; slave: the sequencer
  modport master (
    output acc_data, acc_valid, out_ready,
    input  acc_ready, out_data, out_valid, out_ch, out_last
  );
  modport slave (
    input  acc_data, acc_valid, out_ready,
    output acc_ready, out_data, out_valid, out_ch, out_last
  );
endinterface

`default_nettype wire

// File: rtl/bias_sequencer_fire5_squeeze_bias_relu_sat.sv
// ----------------------------------------------------------------------------
// bias_relu_sat: combinational bias add, arithmetic right shift, ReLU and
// saturation to a non-negative OUT_W activation.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bias_relu_sat #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] bias,
  output logic [OUT_W-1:0] result
);
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_sh;

  always_comb begin
    // one guard bit so the add can never wrap
    w_sum = $signed({acc[ACC_W-1], acc}) + $signed({bias[ACC_W-1], bias});
    w_sh  = w_sum >>> SHIFT;
    if (w_sh[ACC_W]) begin
      result = '0;
    end else if (|w_sh[ACC_W-1:OUT_W-1]) begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      result = w_sh[OUT_W-1:0];
    end
  end
endmodule

`default_nettype wire

// File: rtl/bias_sequencer_fire5_squeeze.sv
// ----------------------------------------------------------------------------
// bias_sequencer_fire5_squeeze: walks channels/pixels of one feature map,
// biases each accumulator result and streams activations out.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bias_sequencer_fire5_squeeze
  import fire5_squeeze_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PIX_W-1:0]    num_pix,
  output logic                busy,
  output logic                done,
  input  logic [ACC_W-1:0]    bias_mem [NUM_CH],
  bias_sequencer_fire5_squeeze_if.slave bus
);
  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [PIX_W-1:0] num_pix_q, num_pix_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             out_last_q, out_last_d;

  logic             w_acc_ready;
  logic             w_accept;
  logic             w_handshake;
  logic             w_last_elem;
  logic [OUT_W-1:0] w_result;

  bias_relu_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_bias_relu_sat (
    .acc    (bus.acc_data),
    .bias   (bias_mem[ch_q]),
    .result (w_result)
  );

  assign w_last_elem = (ch_q == CH_W'(NUM_CH - 1)) && (pix_q == num_pix_q - PIX_W'(1));
  assign w_handshake = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pix_d       = pix_q;
    num_pix_d   = num_pix_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    w_acc_ready = 1'b0;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // a same-cycle accept below overrides this clear
    if (w_handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_pix != '0) begin
            num_pix_d = num_pix;
            ch_d      = '0;
            pix_d     = '0;
            state_d   = RUN;
          end else begin
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        busy        = 1'b1;
        w_acc_ready = !out_valid_q || bus.out_ready;
        w_accept    = w_acc_ready && bus.acc_valid;
        if (w_accept) begin
          out_valid_d = 1'b1;
          out_data_d  = w_result;
          out_ch_d    = ch_q;
          out_last_d  = w_last_elem;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            ch_d  = '0;
            pix_d = pix_q + PIX_W'(1);
          end else begin
            ch_d  = ch_q + CH_W'(1);
          end
          if (w_last_elem) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_handshake) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      pix_q       <= '0;
      num_pix_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      num_pix_q   <= num_pix_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.acc_ready = w_acc_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
endmodule

`default_nettype wire

// File: tb/tb_bias_sequencer_fire5_squeeze.sv
// ----------------------------------------------------------------------------
// tb_bias_sequencer_fire5_squeeze: scoreboard bench for the fire5 squeeze
// bias sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bias_sequencer_fire5_squeeze;
  import fire5_squeeze_pkg::*;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CH_W-1:0]  ch;
    logic             last;
  } pkt_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [PIX_W-1:0] num_pix;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] bias_mem [NUM_CH];
  logic [ACC_W-1:0] stim [64];

  bias_sequencer_fire5_squeeze_if bus();

  bias_sequencer_fire5_squeeze dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_pix  (num_pix),
    .busy     (busy),
    .done     (done),
    .bias_mem (bias_mem),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_acc_cyc = -1;
  logic busy_at_done = 1'b1;
  int   m_ch, m_pix, m_npix;
  pkt_t exp_q[$];
  pkt_t obs_q[$];

  function automatic logic [OUT_W-1:0] ref_act(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    s = s >>> SHIFT;
    if (s < 0) return '0;
    if (s > 32767) return 16'd32767;
    return OUT_W'(s);
  endfunction

  // one clock: drive at negedge, sample 1 time unit later
  task automatic cycle(input logic v, input logic [ACC_W-1:0] d, input logic rdy, output logic acc_ok);
    pkt_t p;
    @(negedge clk);
    start         = 1'b0;
    bus.acc_valid = v;
    bus.acc_data  = d;
    bus.out_ready = rdy;
    #1;
    cyc++;
    acc_ok = bus.acc_valid && bus.acc_ready;
    if (bus.out_valid && bus.out_ready)
      obs_q.push_back(pkt_t'{bus.out_data, bus.out_ch, bus.out_last});
    if (acc_ok) begin
      p.data = ref_act(d, bias_mem[m_ch]);
      p.ch   = CH_W'(m_ch);
      p.last = (m_ch == NUM_CH - 1) && (m_pix == m_npix - 1);
      exp_q.push_back(p);
      last_acc_cyc = cyc;
      if (m_ch == NUM_CH - 1) begin
        m_ch = 0;
        m_pix++;
      end else begin
        m_ch++;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic start_map(input int n, input logic v);
    @(negedge clk);
    start         = 1'b1;
    num_pix       = PIX_W'(n);
    bus.acc_valid = v;
    bus.out_ready = 1'b1;
    m_ch = 0; m_pix = 0; m_npix = n;
    exp_q.delete(); obs_q.delete();
    done_cnt = 0;
  endtask

  task automatic feed(input int first, input int last, output bit ok);
    logic a;
    int   idx;
    idx = first;
    for (int k = 0; k < 4000 && idx < last; k++) begin
      cycle(1'b1, stim[idx], 1'b1, a);
      if (a) idx++;
    end
    ok = (idx == last);
  endtask

  task automatic drain(output bit ok);
    logic a;
    for (int k = 0; k < 50 && done_cnt == 0; k++) cycle(1'b0, '0, 1'b1, a);
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, bus.acc_ready, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b acc_ready=%b out_valid=%b out_data=%0d out_ch=%0d out_last=%b, expected all 0",
               busy, done, bus.acc_ready, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic a;
    bit   ok;
    pkt_t o, e;
    for (int i = 0; i < 32; i++) stim[i] = $urandom;
    stim[0]  = 32'd4096;
    stim[1]  = -32'sd500;
    stim[13] = 32'h7FFF_FFFF;
    start_map(1, 1'b0);
    cycle(1'b0, '0, 1'b1, a);
    n_checks++;
    if (bus.acc_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_run_entry: got acc_ready=%b busy=%b, expected 1 1", bus.acc_ready, busy);
    end
    cycle(1'b1, stim[0], 1'b0, a);
    n_checks++;
    if (a !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: got accept=%b out_valid=%b, expected 1 0", a, bus.out_valid);
    end
    cycle(1'b0, '0, 1'b0, a);
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.out_last} !== {1'b1, 16'd15, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%b data=%0d ch=%0d last=%b, expected 1 15 0 0",
               bus.out_valid, bus.out_data, bus.out_ch, bus.out_last);
    end
    feed(1, 32, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_feed: got timeout, expected 32 accepts"); end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no done, expected done pulse"); end
    n_checks++;
    if (obs_q.size() !== 32) begin
      n_fail++;
      $display("FAIL basic_count: got %0d outputs, expected 32", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[1].data !== 16'd0) begin
        n_fail++; $display("FAIL basic_relu: got %0d, expected 0", obs_q[1].data);
      end
      n_checks++;
      if (obs_q[13].data !== 16'd32767) begin
        n_fail++; $display("FAIL basic_saturate: got %0d, expected 32767", obs_q[13].data);
      end
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_sb: got data=%0d ch=%0d last=%b, expected data=%0d ch=%0d last=%b",
                 o.data, o.ch, o.last, e.data, e.ch, e.last);
      end
    end
  endtask

  task automatic test_full_map();
    bit   ok;
    int   c0, n_last, i;
    pkt_t o, e;
    for (int k = 0; k < 64; k++) stim[k] = $urandom;
    start_map(2, 1'b0);
    c0 = cyc;
    feed(0, 64, ok);
    n_checks++;
    if (!ok || (cyc - c0) !== 64) begin
      n_fail++;
      $display("FAIL full_throughput: got %0d cycles ok=%0d, expected 64 cycles", cyc - c0, ok);
    end
    drain(ok);
    n_checks++;
    if (!ok || (done_cyc - last_acc_cyc) !== 2 || busy_at_done !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL full_done: got delay=%0d busy=%b pulses=%0d, expected delay=2 busy=0 pulses=1",
               done_cyc - last_acc_cyc, busy_at_done, done_cnt);
    end
    n_checks++;
    if (obs_q.size() !== 64) begin
      n_fail++;
      $display("FAIL full_count: got %0d outputs, expected 64", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[31].ch !== 5'd31 || obs_q[32].ch !== 5'd0) begin
        n_fail++;
        $display("FAIL full_ch_wrap: got %0d -> %0d, expected 31 -> 0", obs_q[31].ch, obs_q[32].ch);
      end
      n_last = 0;
      foreach (obs_q[k]) if (obs_q[k].last) n_last++;
      n_checks++;
      if (n_last !== 1 || obs_q[63].last !== 1'b1) begin
        n_fail++;
        $display("FAIL full_last: got %0d lasts, final=%b, expected 1 on output 64", n_last, obs_q[63].last);
      end
    end
    i = 0;
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL full_sb[%0d]: got data=%0d ch=%0d last=%b, expected data=%0d ch=%0d last=%b",
                 i, o.data, o.ch, o.last, e.data, e.ch, e.last);
      end
      i++;
    end
  endtask

  task automatic test_backpressure();
    logic             a, rdy;
    bit               ok;
    int               idx;
    logic [OUT_W-1:0] held_data;
    logic [CH_W-1:0]  held_ch;
    pkt_t             o, e;
    for (int k = 0; k < 32; k++) stim[k] = $urandom;
    start_map(1, 1'b0);
    idx = 0;
    held_data = '0;
    held_ch   = '0;
    for (int k = 0; k < 400 && idx < 32; k++) begin
      rdy = !(k >= 12 && k < 17);
      cycle(1'b1, stim[idx], rdy, a);
      if (a) idx++;
      if (!rdy) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.acc_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall[%0d]: got out_valid=%b acc_ready=%b, expected 1 0", k, bus.out_valid, bus.acc_ready);
        end
        if (k == 12) begin
          held_data = bus.out_data;
          held_ch   = bus.out_ch;
        end else begin
          n_checks++;
          if (bus.out_data !== held_data || bus.out_ch !== held_ch) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got data=%0d ch=%0d, expected data=%0d ch=%0d",
                     k, bus.out_data, bus.out_ch, held_data, held_ch);
          end
        end
      end
    end
    drain(ok);
    n_checks++;
    if (idx !== 32 || !ok || obs_q.size() !== 32) begin
      n_fail++;
      $display("FAIL bp_count: got accepts=%0d outputs=%0d done=%0d, expected 32 32 1", idx, obs_q.size(), ok);
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bp_sb: got data=%0d ch=%0d last=%b, expected data=%0d ch=%0d last=%b",
                 o.data, o.ch, o.last, e.data, e.ch, e.last);
      end
    end
  endtask

  task automatic test_zero_pix();
    logic a;
    start_map(0, 1'b1);
    cycle(1'b1, 32'h1234, 1'b1, a);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b busy=%b accept=%b, expected 1 0 0", done, busy, a);
    end
    cycle(1'b1, 32'h1234, 1'b1, a);
    n_checks++;
    if (done !== 1'b0 || a !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL zero_after: got done=%b accept=%b pulses=%0d, expected 0 0 1", done, a, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    bit   ok;
    pkt_t o, e;
    for (int k = 0; k < 64; k++) stim[k] = $urandom;
    start_map(2, 1'b0);
    feed(0, 10, ok);
    @(negedge clk);
    rst           = 1'b1;
    bus.acc_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, done, bus.acc_ready, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy=%b done=%b acc_ready=%b out_valid=%b out_data=%0d out_ch=%0d out_last=%b, expected all 0",
               busy, done, bus.acc_ready, bus.out_valid, bus.out_data, bus.out_ch, bus.out_last);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cycle(1'b1, stim[0], 1'b1, a);
    n_checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || bus.acc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got pulses=%0d busy=%b acc_ready=%b, expected 0 0 0", done_cnt, busy, bus.acc_ready);
    end
    start_map(1, 1'b0);
    feed(0, 32, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_feed: got timeout, expected 32 accepts"); end
    drain(ok);
    n_checks++;
    if (!ok || obs_q.size() !== 32) begin
      n_fail++;
      $display("FAIL midrst_restart: got done=%0d outputs=%0d, expected 1 32", ok, obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].ch !== 5'd0 || obs_q[31].last !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_origin: got first ch=%0d final last=%b, expected 0 1", obs_q[0].ch, obs_q[31].last);
      end
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrst_sb: got data=%0d ch=%0d last=%b, expected data=%0d ch=%0d last=%b",
                 o.data, o.ch, o.last, e.data, e.ch, e.last);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_pix       = '0;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) bias_mem[k] = $urandom;
    bias_mem[0]  = -32'sd91;
    bias_mem[1]  = 32'sd145;
    bias_mem[13] = 32'sd1280;

    test_reset();
    test_basic();
    test_full_map();
    test_backpressure();
    test_zero_pix();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire

// File: doc/bias_sequencer_fire5_squeeze.md
Name: bias_sequencer_fire5_squeeze

Overview:
- Sequences per-channel bias addition for the fire5 squeeze layer: 32-bit accumulator results stream in, channel-ordered per pixel.
- Selects the matching entry from the fire5 squeeze bias bank, adds it, then applies arithmetic right shift, ReLU and saturation.
- Emits OUT_W activations to the expand stage over valid/ready.
- Sits between the squeeze MAC array and the fire5 expand input buffer; a layer-level controller starts it once per feature map.

Parameters:
NUM_CH, 32, output channels per pixel (bias bank depth)
ACC_W, 32, accumulator and bias width (two's complement)
OUT_W, 16, activation width (two's complement, result always >= 0)
SHIFT, 8, arithmetic right shift applied after bias add
PIX_W, 10, pixel counter width (fire5 map 27x27 = 729)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begin a feature map (honoured in IDLE only)
num_pix  in  PIX_W  pixels in this map, sampled on accepted start
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the map completes
bias_mem  in  ACC_W x NUM_CH  unpacked bias array from the bias bank
acc_data  in  ACC_W  accumulator result
acc_valid  in  1  acc_data valid
acc_ready  out  1  sequencer accepts acc_data
out_data  out  OUT_W  biased, shifted, ReLU'd, saturated activation
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_ch  out  $clog2(NUM_CH)  channel index of out_data
out_last  out  1  marks the final activation of the map

Behaviour:
- Reset values: state IDLE; ch = 0; pix = 0. Outputs busy, done, acc_ready, out_valid, out_data, out_ch and out_last are all 0. A mid-run reset aborts the map and discards the held output; done is not pulsed.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - acc_ready = 0.
  - start with num_pix != 0: latch num_pix, clear ch and pix, go to RUN.
  - start with num_pix == 0: go to DONE.
- RUN:
  - acc_ready = !out_valid || out_ready (single output register, full throughput).
  - Accept when acc_valid && acc_ready.
  - On accept:
    - sum = sext(acc_data) + sext(bias_mem[ch]) in ACC_W+1 bits.
    - sh = sum >>> SHIFT.
    - If sh < 0, result = 0; else if sh > 2^(OUT_W-1)-1, result = 2^(OUT_W-1)-1; else result = sh.
    - Register out_data, out_ch = ch, out_last = (ch == NUM_CH-1 && pix == num_pix-1), out_valid = 1.
    - ch increments. At NUM_CH-1 it wraps to 0 and pix increments.
  - Accepting the last element moves the FSM to DRAIN.
- DRAIN: acc_ready = 0. When out_valid && out_ready, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Output register:
  - out_valid and out_data hold stable while out_ready is low.
  - out_valid clears on handshake unless a new element is accepted in the same cycle; a simultaneous drain and accept loads the new element.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 element/cycle with out_ready held high.
- start while busy is ignored. acc_valid in IDLE or DRAIN is not acknowledged.
- bias_mem is treated as static during a map.

Decomposition:
- Package fire5_squeeze_pkg holds:
  - NUM_CH, CH_W = $clog2(NUM_CH), ACC_W, OUT_W;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - OUT_MAX constant.
- Sub-module bias_relu_sat: purely combinational add, shift, ReLU and saturate. It is instantiated once and reused by the expand-layer sequencers.

Test Plan:
- Basic path: start with num_pix=1, bias0 = -91, acc 4096 on ch0 -> out_data 15, out_ch 0, 1-cycle latency.
- ReLU: bias1 = 145, acc -500 -> sum -355 -> out_data 0.
- Saturation: bias13 = 1280, acc 0x7FFFFFFF -> no wrap in the ACC_W+1 adder, out_data 32767.
- Full map with num_pix=2 and continuous valid/ready -> 64 outputs:
  - out_ch wraps 31 -> 0;
  - out_last only on the 64th output;
  - done pulses 2 cycles after the last accept (DRAIN then DONE);
  - busy falls with done.
- Backpressure:
  - out_ready low for 5 cycles mid-map -> out_data and out_ch held stable, acc_ready low, no element lost or duplicated.
  - num_pix=0 -> done pulses 1 cycle after start, no acc_ready.
- Reset at element 10 of a map -> next cycle everything is 0 and state is IDLE, no done pulse. A new start then begins at ch 0, pix 0.
